mc_controller: RTL
==================

Name: mc_controller

Overview:
- Multicycle successor to the single-cycle MIPS controller: one opcode/funct decoder plus a Moore FSM that sequences a shared-ALU, shared-memory datapath over 3–5 cycles per instruction.
- Adds a memory request/ready handshake (wait states), optional bne/addi support, a parametrised ALU-control width, and illegal-instruction detection.
- Sits beside the multicycle datapath; drives its mux selects and write enables.

Parameters:
- ALUCTRL_W, 3, alucontrol width (≥3); bits above [2:0] are driven 0.
- HAS_BNE, 1, 1 = decode bne (op 000101); 0 = bne is illegal.
- HAS_ADDI, 1, 1 = decode addi (op 001000); 0 = addi is illegal.
- MEM_HANDSHAKE, 1, 1 = honour mem_ready; 0 = mem_ready is ignored and treated as 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- op  in  6  instr[31:26], from the instruction register.
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access requested.
- iord  out  1  0 = PC address, 1 = ALUOut address.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  instruction-register load.
- mdrwrite  out  1  data-register load.
- pcen  out  1  PC load.
- pcsrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
- alusrca  out  1  0 = PC, 1 = A.
- alusrcb  out  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- alucontrol  out  ALUCTRL_W  ALU operation.
- regdst  out  1  1 = rd, 0 = rt.
- memtoreg  out  1  1 = MDR, 0 = ALUOut.
- regwrite  out  1  register-file write.
- illegal  out  1  one-cycle pulse on an undecodable instruction.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Outputs are Moore (state-decoded). Exceptions: pcen in BRANCH depends on zero; write enables in handshake states also depend on mem_ready.
- Any output not listed for a state is 0.
- ALU codes: add = 010, sub = 110, and = 000, or = 001, slt = 111.
- While reset = 0, all outputs are forced to 0. Only on the first clock edge sampled with reset = 0 does the state register load FETCH; assertion mid-instruction aborts the instruction and then loads FETCH the same way.
- FETCH:
  - Outputs: mem_req = 1, iord = 0, alusrca = 0, alusrcb = 01, alucontrol = add, pcsrc = 00.
  - irwrite and pcen = mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - Outputs: alusrca = 0, alusrcb = 11, alucontrol = add (branch target into ALUOut).
  - Next state by op: lw/sw → MEMADR; R-type → EXEC; beq, and bne if HAS_BNE → BRANCH; addi if HAS_ADDI → ADDIEX; j → JUMP.
  - Any other op, or R-type with funct not in {add, sub, and, or, slt}: illegal = 1 for this cycle, next state FETCH, no register or memory write.
- MEMADR: alusrca = 1, alusrcb = 10, add. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req = 1, iord = 1, mdrwrite = mem_ready. Holds until mem_ready, then MEMWB.
- MEMWB: regwrite = 1, regdst = 0, memtoreg = 1. Then FETCH.
- MEMWR: mem_req = 1, iord = 1, memwrite = mem_ready (single-cycle strobe). Holds until mem_ready, then FETCH.
- EXEC: alusrca = 1, alusrcb = 00, alucontrol from funct. Then ALUWB.
- ALUWB: regwrite = 1, regdst = 1, memtoreg = 0. Then FETCH.
- BRANCH:
  - Outputs: alusrca = 1, alusrcb = 00, sub, pcsrc = 01.
  - pcen = zero for beq, ~zero for bne (op is stable from the IR).
  - Then FETCH.
- ADDIEX: alusrca = 1, alusrcb = 10, add. Then ADDIWB.
- ADDIWB: regwrite = 1, regdst = 0, memtoreg = 0. Then FETCH.
- JUMP: pcsrc = 10, pcen = 1. Then FETCH.
- Latency with mem_ready tied high:
  - lw = 5 cycles.
  - sw, R-type, addi = 4 cycles.
  - beq/bne, j = 3 cycles.
  - Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready outside the handshake states is ignored.
- mem_req stays high continuously through a wait; it is never dropped mid-access.

Decomposition:
- Shared package holds: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J), funct constants, ALU code constants, and the state enum.
- One natural sub-module: mc_aludec — combinational funct → alucontrol plus a funct_valid flag, reused by the FSM for EXEC and illegal detection.

Test Plan:
- Reset: hold reset = 0 for 3 cycles with random op → all outputs 0. Release → cycle 1 in FETCH with mem_req = 1, alusrcb = 01, alucontrol = 010.
- lw, mem_ready = 1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. regwrite = 1 only in cycle 5, with memtoreg = 1 and regdst = 0.
- sw with mem_ready low for 2 cycles in MEMWR:
  - mem_req = 1, iord = 1 held for 3 cycles.
  - memwrite = 1 only in the third.
  - Then FETCH.
- beq with zero = 1 → pcen = 1, pcsrc = 01 in cycle 3. bne with zero = 1 → pcen = 0. Set HAS_BNE = 0: bne → illegal pulse in DECODE, back to FETCH.
- R-type funct 100010 → alucontrol = 110 in EXEC, then regdst = 1 write. funct 000000 → illegal = 1, no regwrite.
- Reset asserted in MEMRD while waiting → outputs 0 immediately. After release, restarts in FETCH; no mdrwrite or regwrite from the aborted lw.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller:
// opcodes, functs, ALU operation codes and FSM states.
package mc_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

endpackage

// File: rtl/mc_controller_aludec.sv
// R-type funct decoder: funct -> 3-bit ALU code plus valid flag.
// Ports: funct in, alu (3b) out, funct_valid out.
module mc_controller_aludec
  import mc_controller_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu,
  output logic       funct_valid
);

  always_comb begin
    alu         = ALU_ADD;
    funct_valid = 1'b1;
    unique case (funct)
      F_ADD:   alu = ALU_ADD;
      F_SUB:   alu = ALU_SUB;
      F_AND:   alu = ALU_AND;
      F_OR:    alu = ALU_OR;
      F_SLT:   alu = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS controller: opcode decode plus Moore FSM with
// memory handshake. Ports: clk, reset (sync, low), op, funct, zero,
// mem_ready in; datapath selects/enables and illegal pulse out.
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int ALUCTRL_W     = 3,
  parameter bit HAS_BNE       = 1'b1,
  parameter bit HAS_ADDI      = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 mdrwrite,
  output logic                 pcen,
  output logic [1:0]           pcsrc,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 illegal
);

  state_t     state;
  state_t     dec_next;
  logic [2:0] fn_alu;
  logic [2:0] alu;
  logic       fn_ok;
  logic       rdy;
  logic       legal;
  logic       is_r, is_lw, is_sw, is_beq;
  logic       is_bne, is_addi, is_j;

  mc_controller_aludec u_aludec (
    .funct       (funct),
    .alu         (fn_alu),
    .funct_valid (fn_ok)
  );

  assign rdy     = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign is_r    = (op == OP_RTYPE);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_bne  = HAS_BNE && (op == OP_BNE);
  assign is_addi = HAS_ADDI && (op == OP_ADDI);
  assign is_j    = (op == OP_J);

  assign legal = is_lw | is_sw | (is_r & fn_ok)
               | is_beq | is_bne | is_addi | is_j;

  // legal guarantees exactly one class matches
  always_comb begin
    dec_next = S_FETCH;
    if (legal) begin
      unique case (1'b1)
        is_lw | is_sw:   dec_next = S_MEMADR;
        is_r:            dec_next = S_EXEC;
        is_beq | is_bne: dec_next = S_BRANCH;
        is_addi:         dec_next = S_ADDIEX;
        default:         dec_next = S_JUMP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      unique case (state)
        S_FETCH:  if (rdy) state <= S_DECODE;
        S_DECODE: state <= dec_next;
        S_MEMADR: state <= is_sw ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (rdy) state <= S_MEMWB;
        S_MEMWB:  state <= S_FETCH;
        S_MEMWR:  if (rdy) state <= S_FETCH;
        S_EXEC:   state <= S_ALUWB;
        S_ALUWB:  state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        S_ADDIEX: state <= S_ADDIWB;
        S_ADDIWB: state <= S_FETCH;
        S_JUMP:   state <= S_FETCH;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Reset gates everything so outputs drop the same cycle it asserts
  always_comb begin
    mem_req  = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    mdrwrite = 1'b0;
    pcen     = 1'b0;
    pcsrc    = 2'b00;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    alu      = 3'b000;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    illegal  = 1'b0;
    if (reset) begin
      unique case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          alusrcb = 2'b01;
          alu     = ALU_ADD;
          irwrite = rdy;
          pcen    = rdy;
        end
        S_DECODE: begin
          alusrcb = 2'b11;
          alu     = ALU_ADD;
          illegal = ~legal;
        end
        S_MEMADR, S_ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          alu     = ALU_ADD;
        end
        S_MEMRD: begin
          mem_req  = 1'b1;
          iord     = 1'b1;
          mdrwrite = rdy;
        end
        S_MEMWB: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        S_MEMWR: begin
          mem_req  = 1'b1;
          iord     = 1'b1;
          memwrite = rdy;
        end
        S_EXEC: begin
          alusrca = 1'b1;
          alu     = fn_alu;
        end
        S_ALUWB: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        S_BRANCH: begin
          alusrca = 1'b1;
          alu     = ALU_SUB;
          pcsrc   = 2'b01;
          pcen    = is_bne ? ~zero : zero;
        end
        S_ADDIWB: regwrite = 1'b1;
        S_JUMP: begin
          pcsrc = 2'b10;
          pcen  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    alucontrol      = '0;
    alucontrol[2:0] = alu;
  end

endmodule
